// File: rtl/mcs4_pkg.sv
// Shared types and constants for the MCS-4 i4003 load sequencer.
package mcs4_pkg;

  localparam int SR_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } sr_state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester not granted last.
module sr_rr_arb2
  import mcs4_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_idle,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_idle) begin
      if (i_valid[0] && (!i_valid[1] || r_last == REQ_HOST)) o_grant[0] = 1'b1;
      else if (i_valid[1])                                    o_grant[1] = 1'b1;
    end
  end

  // Reset points at the host so the CPU wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_last <= REQ_HOST;
    else if (|o_grant) r_last <= o_grant[1] ? REQ_HOST : REQ_CPU;
  end

endmodule

// File: rtl/sr_load_ctrl.sv
// Handshaked i4003 load sequencer: arbitrate, shift MSB-first on cp, strobe enable.
// Optional macro SR_READBACK_EN adds sr_serial_out / prev_word readback of displaced contents.
module sr_load_ctrl
  import mcs4_pkg::*;
#(
  parameter int SR_WIDTH       = SR_WIDTH_DEFAULT,
  parameter int CP_DIV         = 4,
  parameter int BLANK_ON_SHIFT = 1
) (
  input  logic                sysclk,
  input  logic                poc_n,
  input  logic                req0_valid,
  input  logic [SR_WIDTH-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SR_WIDTH-1:0] req1_data,
  output logic                req1_ready,
`ifdef SR_READBACK_EN
  input  logic                sr_serial_out,
  output logic [SR_WIDTH-1:0] prev_word,
`endif
  output logic                sr_data,
  output logic                sr_cp,
  output logic                sr_enable,
  output logic                busy,
  output logic                done,
  output logic                grant_id,
  output sr_state_t           dbg_state
);

  // Handshake: a word transfers on the cycle where reqN_valid && reqN_ready;
  // ready is a combinational one-cycle pulse in IDLE, so a requester may drop
  // valid before ready at any time, and must hold data stable while valid is high.

  localparam int  CW      = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam bit  W_BLANK = (BLANK_ON_SHIFT != 0);

  sr_state_t           r_state, w_state_nxt;
  logic [7:0]          r_div;
  logic [CW-1:0]       r_bit;
  logic [SR_WIDTH-1:0] r_word;
  logic                r_gid;
  logic                r_loaded;
  logic                r_armed;
  logic [1:0]          w_grant;
  logic                w_div_end;
  logic                w_shifting;

  sr_rr_arb2 u_arb (
    .i_clk   (sysclk),
    .i_rst_n (poc_n),
    .i_valid ({req1_valid, req0_valid}),
    .i_idle  ((r_state == IDLE) && r_armed),
    .o_grant (w_grant)
  );

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_end   = (r_div == 8'd0);
    w_shifting  = (r_state == SHIFT_LO) || (r_state == SHIFT_HI);
    case (r_state)
      IDLE:     if (|w_grant) w_state_nxt = SHIFT_LO;
      SHIFT_LO: if (w_div_end) w_state_nxt = SHIFT_HI;
      SHIFT_HI: if (w_div_end) w_state_nxt = (r_bit == '0) ? LATCH : SHIFT_LO;
      LATCH:    w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
    req0_ready = w_grant[0];
    req1_ready = w_grant[1];
    grant_id   = (|w_grant) ? w_grant[1] : r_gid;
    sr_cp      = (r_state == SHIFT_HI);
    sr_data    = w_shifting && r_word[SR_WIDTH-1];
    busy       = w_shifting;
    done       = (r_state == LATCH);
    sr_enable  = (r_state == LATCH) || (r_loaded && !(W_BLANK && w_shifting));
    dbg_state  = r_state;
  end

  // Divider reloads on every state change so each phase lasts exactly CP_DIV cycles.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_div    <= 8'(CP_DIV - 1);
      r_bit    <= '0;
      r_word   <= '0;
      r_gid    <= REQ_CPU;
      r_loaded <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (r_state != w_state_nxt) r_div <= 8'(CP_DIV - 1);
      else if (!w_div_end)        r_div <= r_div - 8'd1;
      if (r_state == IDLE && |w_grant) begin
        r_word <= w_grant[1] ? req1_data : req0_data;
        r_bit  <= CW'(SR_WIDTH - 1);
        r_gid  <= w_grant[1] ? REQ_HOST : REQ_CPU;
      end
      if (r_state == SHIFT_HI && w_div_end && r_bit != '0) begin
        r_word <= {r_word[SR_WIDTH-2:0], 1'b0};
        r_bit  <= r_bit - CW'(1);
      end
      if (r_state == LATCH) r_loaded <= 1'b1;
    end
  end

`ifdef SR_READBACK_EN
  logic [SR_WIDTH-1:0] r_cap, r_prev;

  // Serial_out is the bit about to be displaced by the next rising cp.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_cap  <= '0;
      r_prev <= '0;
    end else begin
      if (r_state == SHIFT_LO && w_div_end) r_cap <= {r_cap[SR_WIDTH-2:0], sr_serial_out};
      if (r_state == SHIFT_HI && w_state_nxt == LATCH) r_prev <= r_cap;
    end
  end

  assign prev_word = r_prev;
`endif

endmodule

// File: tb/tb_sr_load_ctrl.sv
// Directed bench for sr_load_ctrl: instance A (CP_DIV=2, blanking) and B (CP_DIV=1, no blanking).
module tb_sr_load_ctrl;
  import mcs4_pkg::*;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_vec  = 0;
  int n_miss = 0;

  logic       a_v0 = 0, a_v1 = 0, a_r0, a_r1, a_sd, a_cp, a_en, a_busy, a_done, a_gid;
  logic [9:0] a_d0 = '0, a_d1 = '0;
  logic       b_v0 = 0, b_v1 = 0, b_r0, b_r1, b_sd, b_cp, b_en, b_busy, b_done, b_gid;
  logic [9:0] b_d0 = '0, b_d1 = '0;
  sr_state_t  a_state, b_state;
  logic [9:0] a_model = '0, b_model = '0;
`ifdef SR_READBACK_EN
  logic [9:0] a_prev, b_prev;
`endif

  sr_load_ctrl #(.SR_WIDTH(10), .CP_DIV(2), .BLANK_ON_SHIFT(1)) u_dut_a (
    .sysclk(sysclk), .poc_n(poc_n),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
`ifdef SR_READBACK_EN
    .sr_serial_out(a_model[9]), .prev_word(a_prev),
`endif
    .sr_data(a_sd), .sr_cp(a_cp), .sr_enable(a_en), .busy(a_busy),
    .done(a_done), .grant_id(a_gid), .dbg_state(a_state)
  );

  sr_load_ctrl #(.SR_WIDTH(10), .CP_DIV(1), .BLANK_ON_SHIFT(0)) u_dut_b (
    .sysclk(sysclk), .poc_n(poc_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
`ifdef SR_READBACK_EN
    .sr_serial_out(b_model[9]), .prev_word(b_prev),
`endif
    .sr_data(b_sd), .sr_cp(b_cp), .sr_enable(b_en), .busy(b_busy),
    .done(b_done), .grant_id(b_gid), .dbg_state(b_state)
  );

  // i4003 behaviour: shift serial_in in on each rising cp.
  always @(posedge a_cp) a_model <= {a_model[8:0], a_sd};
  always @(posedge b_cp) b_model <= {b_model[8:0], b_sd};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk(tag, 32'({a_sd, a_cp, a_en, a_busy, a_done, a_r0, a_r1, a_gid}), 32'd0);
    chk({tag, "_state"}, 32'(a_state), 32'(IDLE));
  endtask

  task automatic accept_a(input logic id, input logic [9:0] word);
    @(negedge sysclk);
    if (id) begin a_v1 = 1'b1; a_d1 = word; end
    else    begin a_v0 = 1'b1; a_d0 = word; end
    #1;
    chk("accept_ready", 32'({a_r1, a_r0}), id ? 32'd2 : 32'd1);
    chk("accept_gid", 32'(a_gid), 32'(id));
  endtask

  task automatic finish_a(output int lat);
    lat = 0;
    do begin
      @(negedge sysclk);
      if (lat == 0) begin a_v0 = 1'b0; a_v1 = 1'b0; end
      #1 lat++;
    end while (!a_done && lat < 300);
  endtask

  initial begin : main
    int         lat, k, done_cyc, bi;
    logic       found;
    logic [9:0] w;

    // Reset values
    repeat (2) @(negedge sysclk);
    #1 chk_reset_a("reset_a");
    chk("reset_b", 32'({b_sd, b_cp, b_en, b_busy, b_done, b_r0, b_r1, b_gid}), 32'd0);
    @(negedge sysclk) poc_n = 1'b1;

    // Single load 2A5: per-cycle serial pattern, 2 low / 2 high per bit
    w = 10'h2A5;
    accept_a(1'b0, w);
    for (int c = 1; c <= 41; c++) begin
      @(negedge sysclk);
      if (c == 1) a_v0 = 1'b0;
      #1;
      bi = (c - 1) / 4;
      if (c <= 40)
        chk($sformatf("shift_c%0d", c), 32'({a_sd, a_cp, a_en, a_busy, a_done}),
            32'({w[9-bi], ((c - 1) % 4) >= 2, 1'b0, 1'b1, 1'b0}));
      else
        chk("latch", 32'({a_sd, a_cp, a_en, a_busy, a_done}), 32'b00101);
    end
    chk("single_model", 32'(a_model), 32'h2A5);
    @(negedge sysclk); #1;
    chk("post_done", 32'({a_en, a_done, a_busy}), 32'b100);

    // Reset, then both requesters held valid: grants 0,1,0 with one-cycle gap
    @(negedge sysclk) poc_n = 1'b0;
    #1 chk_reset_a("reset2");
    @(negedge sysclk) poc_n = 1'b1;
    @(negedge sysclk);
    a_v0 = 1'b1; a_d0 = 10'h001; a_v1 = 1'b1; a_d1 = 10'h3FF;
    k = 0; done_cyc = -10; found = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge sysclk);
      if (k == 3) begin a_v0 = 1'b0; a_v1 = 1'b0; end
      #1;
      if (a_r0 || a_r1) begin
        chk($sformatf("rr_ready%0d", k), 32'({a_r1, a_r0}), (k == 1) ? 32'd2 : 32'd1);
        chk($sformatf("rr_gid%0d", k), 32'(a_gid), (k == 1) ? 32'd1 : 32'd0);
        if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(cyc), 32'(done_cyc + 1));
        k++;
      end
      if (a_done) begin
        chk($sformatf("rr_word%0d", k), 32'(a_model), (k == 2) ? 32'h3FF : 32'h001);
        done_cyc = cyc;
        if (k == 3) begin found = 1'b1; break; end
      end
    end
    chk("rr_grants", 32'(k), 32'd3);
    chk("rr_last_done", 32'(found), 32'd1);

    // req1 raised mid-load is held off until the cycle after LATCH
    accept_a(1'b0, 10'h0C3);
    found = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge sysclk);
      if (c == 1) a_v0 = 1'b0;
      if (c == 10) begin a_v1 = 1'b1; a_d1 = 10'h3C0; end
      #1;
      if (a_done) begin
        chk("blk_done_cyc", 32'(c), 32'd41);
        chk("blk_r1_latch", 32'(a_r1), 32'd0);
        found = 1'b1;
        break;
      end
      if (c >= 10) chk($sformatf("blk_r1_c%0d", c), 32'(a_r1), 32'd0);
    end
    chk("blk_done_seen", 32'(found), 32'd1);
    chk("blk_model0", 32'(a_model), 32'h0C3);
    @(negedge sysclk); #1;
    chk("blk_grant", 32'({a_r1, a_r0}), 32'd2);
    chk("blk_gid", 32'(a_gid), 32'd1);
    finish_a(lat);
    chk("blk_lat", 32'(lat), 32'd41);
    chk("blk_model1", 32'(a_model), 32'h3C0);

    // Reset at bit 5, then a clean load of 155
    accept_a(1'b0, 10'h0AA);
    repeat (21) begin
      @(negedge sysclk);
      a_v0 = 1'b0;
    end
    #1 chk("mid_busy", 32'({a_busy, a_en}), 32'b10);
    #1 poc_n = 1'b0;
    #1 chk_reset_a("mid_reset");
    @(negedge sysclk) poc_n = 1'b1;
    accept_a(1'b0, 10'h155);
    finish_a(lat);
    chk("after_rst_lat", 32'(lat), 32'd41);
    chk("after_rst_model", 32'(a_model), 32'h155);
    chk("after_rst_en", 32'(a_en), 32'd1);

`ifdef SR_READBACK_EN
    accept_a(1'b0, 10'h0F0);
    finish_a(lat);
    chk("rb_prev0", 32'(a_prev), 32'h155);
    accept_a(1'b1, 10'h00F);
    finish_a(lat);
    chk("rb_prev1", 32'(a_prev), 32'h0F0);
    chk("rb_model", 32'(a_model), 32'h00F);
`endif

    // Instance B: CP_DIV=1, no blanking; enable held after the first load
    @(negedge sysclk) begin b_v0 = 1'b1; b_d0 = 10'h000; end
    #1 chk("b_ready0", 32'(b_r0), 32'd1);
    lat = 0;
    do begin
      @(negedge sysclk);
      if (lat == 0) b_v0 = 1'b0;
      #1 lat++;
    end while (!b_done && lat < 300);
    chk("b_lat0", 32'(lat), 32'd21);
    @(negedge sysclk) begin b_v0 = 1'b1; b_d0 = 10'h3FF; end
    #1 chk("b_ready1", 32'({b_r0, b_en}), 32'b11);
    lat = 0;
    do begin
      @(negedge sysclk);
      if (lat == 0) b_v0 = 1'b0;
      #1 lat++;
      if (!b_done) chk($sformatf("b_en_c%0d", lat), 32'({b_en, b_busy}), 32'b11);
    end while (!b_done && lat < 300);
    chk("b_lat1", 32'(lat), 32'd21);
    chk("b_model", 32'(b_model), 32'h3FF);
    chk("b_latch_en", 32'(b_en), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sr_load_ctrl.md
Name: sr_load_ctrl

Overview:
- Load sequencer for the i4003 shift register in the MCS-4 system.
- Accepts 10-bit output words from two requesters: req0 = CPU RAM-port writer, req1 = host/debug port. Arbitrates between them round-robin.
- Serialises the granted word MSB-first onto the i4003 serial_in/cp pins with programmable cp timing, then strobes enable so the parallel outputs update.
- Replaces the free-running clk2/always-enabled hookup with a deterministic, handshaked load.

Parameters:
- SR_WIDTH, 10, bits per load; matches i4003 parallel_out width.
- CP_DIV, 4, sysclk cycles per cp half-period; legal range 1..255.
- BLANK_ON_SHIFT, 1, when 1 sr_enable is driven low for the whole shift phase.

Ports:
- sysclk  in  1  system clock, 20 MHz.
- poc_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  SR_WIDTH  requester 0 word.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  SR_WIDTH  requester 1 word.
- req1_ready  out  1  one-cycle accept pulse to requester 1.
- sr_data  out  1  to i4003 serial_in.
- sr_cp  out  1  to i4003 cp; the register shifts on the rising edge.
- sr_enable  out  1  to i4003 enable.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse when a load completes.
- grant_id  out  1  id of the requester owning the current or last load.

Behaviour:
- Reset values (poc_n low, asynchronous): state IDLE, sr_data 0, sr_cp 0, sr_enable 0, busy 0, done 0, ready 0, grant_id 0, last-grant pointer points to 1 so req0 wins first.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - If any valid is high, grant one requester: pulse its readyN for one cycle, capture its data into a shift word, load the bit counter with SR_WIDTH-1, set busy, go to SHIFT_LO.
  - Handshake: transfer occurs on the cycle where valid && ready. The requester must hold data stable while valid is high. Valid deasserted before ready is a legal withdraw.
- Arbitration:
  - Only one valid high: that requester is granted.
  - Both high: grant the requester not granted last.
  - grant_id updates in the same cycle as ready.
- SHIFT_LO:
  - sr_cp = 0 and sr_data = current MSB of the shift word, both held CP_DIV cycles.
  - If BLANK_ON_SHIFT, sr_enable = 0.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - sr_cp = 1 for CP_DIV cycles; sr_data is unchanged, which gives the i4003 CP_DIV cycles of setup and hold around the rising edge.
  - At the end: if the bit counter is 0, go to LATCH; else shift the word left, decrement the counter, go to SHIFT_LO.
- LATCH (one cycle):
  - sr_cp = 0, sr_data = 0, sr_enable = 1, done = 1, busy = 0.
  - Next state is IDLE.
  - A new grant is possible on the cycle after LATCH, so back-to-back loads have a one-cycle gap.
- Timing: load latency from the accept cycle to done = 2*CP_DIV*SR_WIDTH + 1 cycles (CP_DIV=4, SR_WIDTH=10 gives 81).
- sr_enable:
  - Stays 1 once any load has completed, except during shift phases when BLANK_ON_SHIFT=1.
  - With BLANK_ON_SHIFT=0 it is untouched during shifts.
- Divider: the divide counter reloads to CP_DIV-1 on every state entry. CP_DIV=1 gives one-cycle half-periods.
- Requests arriving while busy are ignored: ready stays low and they wait.
- Reset mid-load aborts immediately. There is no partial latch; the i4003 is left holding partially shifted contents with enable low.

Optional Feature:
- SR_READBACK_EN defined:
  - Adds output prev_word [SR_WIDTH-1:0] (reset 0) and input sr_serial_out (from i4003 serial_out).
  - sr_serial_out is sampled on the last sysclk cycle of each SHIFT_LO, shifted into a capture register MSB-first, and transferred to prev_word in LATCH.
  - prev_word therefore equals the register contents that were displaced by the load.
- SR_READBACK_EN undefined: the port and all logic are absent.

Decomposition:
- Package mcs4_pkg:
  - SR_WIDTH default constant.
  - sr_state_t enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH}.
  - Requester id constants REQ_CPU=0, REQ_HOST=1.
- Sub-module sr_rr_arb2: two-input round-robin arbiter with last-grant pointer, taking valid pair and an idle qualifier, producing one-hot grant.
- Divider and shifter stay in the top module.

Test Plan:
- Single load, CP_DIV=2: req0 word 10'h2A5.
  - req0_ready pulses once, busy rises.
  - sr_data sequence 1,0,1,0,1,0,0,1,0,1 with sr_cp 2 low/2 high per bit.
  - done 41 cycles after accept; modelled i4003 parallel_out = 10'h2A5.
- Simultaneous requests after reset: req0=10'h001, req1=10'h3FF held valid.
  - Grants in order req0, req1, req0; grant_id 0, 1, 0.
  - Exactly a one-cycle gap between done and the next ready.
- Busy blocking: raise req1 mid-load of req0.
  - req1_ready stays 0 until the cycle after LATCH, then req1 is granted.
- Reset mid-shift: assert poc_n low at bit 5.
  - All outputs return to reset values asynchronously (sr_enable 0, busy 0).
  - Next load of 10'h155 completes correctly.
- CP_DIV=1, BLANK_ON_SHIFT=0: word 10'h3FF.
  - Latency 21 cycles; sr_enable remains 1 throughout after a prior load.
- SR_READBACK_EN: load 10'h0F0, then 10'h00F.
  - prev_word = 10'h0F0 at the second done pulse.
